dmem_arbiter: RTL and testbench

Shares the single data-memory request port of Memory150 between the processor's data port and the graphics bypass write port. CPU accesses are prioritised, with a bounded-starvation guarantee for graphics. The block stalls the pipeline until each CPU access completes. It sits between Riscv150 (dcache_*/bypass_* signals) and the memory system.

---
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single Memory150 data request port between the CPU data
//   port and the graphics bypass write port. CPU accesses win by default;
//   a waiting graphics write is forced through after STARVE_LIMIT
//   consecutive CPU grants. The CPU pipeline is stalled until its access
//   completes.
//
//   Ports
//     clk, rst          : clock, synchronous active-low reset
//     cpu_re/cpu_we     : CPU load request / store byte enables (store wins)
//     cpu_addr/cpu_din  : CPU byte address / store data
//     cpu_dout          : registered data of the last completed load
//     cpu_stall         : pipeline stall while a CPU access is outstanding
//     gfx_valid/addr/din/we : graphics write request, held until accepted
//     gfx_ready         : graphics request accepted this cycle
//     mem_req_valid/ready, mem_addr/din/we : memory request handshake
//     mem_rdata/mem_rdata_valid : memory read return
module dmem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_re,
   input  logic [3:0]  cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_din,
   output logic [31:0] cpu_dout,
   output logic        cpu_stall,
   input  logic        gfx_valid,
   input  logic [31:0] gfx_addr,
   input  logic [31:0] gfx_din,
   input  logic [3:0]  gfx_we,
   output logic        gfx_ready,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic [3:0]  mem_we,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rdata_valid
);

   localparam int unsigned CNT_W =
      ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      IDLE,
      CPU_ISSUE,
      CPU_RDWAIT,
      CPU_DONE,
      GFX_ISSUE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
   logic [31:0]        cpu_dout_q, cpu_dout_d;

   logic               cpu_store;
   logic               cpu_req;

   assign cpu_store = |cpu_we;
   assign cpu_req   = cpu_re | cpu_store;

   // CPU_DONE is the single cycle in which the pipeline advances.
   assign cpu_stall = cpu_req & (state_q != CPU_DONE);
   assign cpu_dout  = cpu_dout_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         cpu_dout_q   <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         cpu_dout_q   <= cpu_dout_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      starve_cnt_d  = starve_cnt_q;
      cpu_dout_d    = cpu_dout_q;
      mem_req_valid = 1'b0;
      mem_addr      = '0;
      mem_din       = '0;
      mem_we        = '0;
      gfx_ready     = 1'b0;

      case (state_q)
         IDLE: begin
            if (gfx_valid && (starve_cnt_q == LIMIT)) begin
               state_d = GFX_ISSUE;
            end else if (cpu_req) begin
               state_d = CPU_ISSUE;
               // Reaching here with gfx_valid implies the count is below the
               // limit, so the increment already saturates at LIMIT.
               if (gfx_valid) begin
                  starve_cnt_d = starve_cnt_q + CNT_W'(1);
               end
            end else if (gfx_valid) begin
               state_d = GFX_ISSUE;
            end
         end

         CPU_ISSUE: begin
            mem_req_valid = 1'b1;
            mem_addr      = cpu_addr;
            mem_din       = cpu_din;
            // A store takes precedence over a simultaneous load; a pure load
            // presents zero byte enables.
            mem_we        = cpu_we;
            if (mem_req_ready) begin
               state_d = cpu_store ? CPU_DONE : CPU_RDWAIT;
            end
         end

         CPU_RDWAIT: begin
            if (mem_rdata_valid) begin
               cpu_dout_d = mem_rdata;
               state_d    = CPU_DONE;
            end
         end

         CPU_DONE: begin
            state_d = IDLE;
         end

         GFX_ISSUE: begin
            mem_req_valid = 1'b1;
            mem_addr      = gfx_addr;
            mem_din       = gfx_din;
            mem_we        = gfx_we;
            gfx_ready     = mem_req_ready;
            if (mem_req_ready) begin
               state_d      = IDLE;
               starve_cnt_d = '0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed scenarios followed by randomized CPU/graphics transactions.
//   A memory responder with programmable accept delay and read latency
//   serves the DUT; a word-level reference memory and a predicted request
//   order (CPU first unless graphics has been starved) supply expectations.
module tb_dmem_arbiter;

   localparam int unsigned LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_re;
   logic [3:0]  cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_din;
   logic [31:0] cpu_dout;
   logic        cpu_stall;
   logic        gfx_valid;
   logic [31:0] gfx_addr;
   logic [31:0] gfx_din;
   logic [3:0]  gfx_we;
   logic        gfx_ready;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [3:0]  mem_we;
   logic [31:0] mem_rdata = '0;
   logic        mem_rdata_valid = 1'b0;

   always #5 clk = ~clk;

   dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk             (clk),
      .rst             (rst),
      .cpu_re          (cpu_re),
      .cpu_we          (cpu_we),
      .cpu_addr        (cpu_addr),
      .cpu_din         (cpu_din),
      .cpu_dout        (cpu_dout),
      .cpu_stall       (cpu_stall),
      .gfx_valid       (gfx_valid),
      .gfx_addr        (gfx_addr),
      .gfx_din         (gfx_din),
      .gfx_we          (gfx_we),
      .gfx_ready       (gfx_ready),
      .mem_req_valid   (mem_req_valid),
      .mem_req_ready   (mem_req_ready),
      .mem_addr        (mem_addr),
      .mem_din         (mem_din),
      .mem_we          (mem_we),
      .mem_rdata       (mem_rdata),
      .mem_rdata_valid (mem_rdata_valid)
   );

   typedef struct packed {
      logic        gfx;
      logic [3:0]  we;
      logic [31:0] din;
      logic [31:0] addr;
   } req_t;

   req_t        exp_q[$];
   req_t        obs_q[$];
   logic [31:0] ref_mem  [256];
   logic [31:0] resp_mem [256];
   logic [31:0] dout_model;
   int unsigned tb_starve;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   int          rdy_delay = 0;
   int          rd_lat    = 1;
   int          wait_cnt  = 0;
   int          cur_delay = 0;
   int          rd_cnt    = 0;
   logic [31:0] rd_word   = '0;

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] din,
                                         input logic [3:0]  we);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (we[b]) r[8*b +: 8] = din[8*b +: 8];
      return r;
   endfunction

   // Memory responder: records each accepted request, then after the edge
   // drives the read return and the ready for the next cycle.
   always @(posedge clk) begin
      if (mem_req_valid && mem_req_ready) begin
         obs_q.push_back('{gfx: gfx_ready, we: mem_we, din: mem_din, addr: mem_addr});
         if (mem_we == 4'h0) begin
            rd_word = resp_mem[mem_addr[9:2]];
            rd_cnt  = rd_lat;
         end else begin
            resp_mem[mem_addr[9:2]] = merge(resp_mem[mem_addr[9:2]], mem_din, mem_we);
         end
      end
      #1;
      mem_rdata_valid = 1'b0;
      if (rd_cnt > 0) begin
         rd_cnt--;
         if (rd_cnt == 0) begin
            mem_rdata       = rd_word;
            mem_rdata_valid = 1'b1;
         end
      end
      if (mem_req_valid) begin
         if (wait_cnt == 0) cur_delay = rdy_delay;
         mem_req_ready = (wait_cnt == cur_delay);
         wait_cnt++;
      end else begin
         wait_cnt      = 0;
         mem_req_ready = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic expect_req(input logic g, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] we);
      exp_q.push_back('{gfx: g, we: we, din: d, addr: a});
   endtask

   task automatic compare_reqs(input string tag);
      req_t e, o;
      check({tag, "_req_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         check({tag, "_req_src"},  32'(o.gfx), 32'(e.gfx));
         check({tag, "_req_addr"}, o.addr, e.addr);
         check({tag, "_req_din"},  o.din, e.din);
         check({tag, "_req_we"},   32'(o.we), 32'(e.we));
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   // One CPU and/or graphics transaction presented together from idle.
   task automatic do_txn(input string tag,
                         input logic c_en, input logic c_re, input logic [3:0] c_we,
                         input logic [31:0] c_addr, input logic [31:0] c_din,
                         input logic g_en, input logic [31:0] g_addr,
                         input logic [31:0] g_din, input logic [3:0] g_we,
                         input int d, input int lat);
      logic c_store, c_req, gfx_first, c_pend, g_pend, g_drop;
      int   stalls, exp_stalls;
      c_store   = c_en && (c_we != 4'h0);
      c_req     = c_en && (c_re || c_store);
      gfx_first = g_en && (!c_req || tb_starve == LIMIT);
      if (gfx_first) begin
         expect_req(1'b1, g_addr, g_din, g_we);
         ref_mem[g_addr[9:2]] = merge(ref_mem[g_addr[9:2]], g_din, g_we);
      end
      if (c_req) begin
         expect_req(1'b0, c_addr, c_din, c_store ? c_we : 4'h0);
         if (c_store) ref_mem[c_addr[9:2]] = merge(ref_mem[c_addr[9:2]], c_din, c_we);
         else         dout_model = ref_mem[c_addr[9:2]];
      end
      if (g_en && !gfx_first) begin
         expect_req(1'b1, g_addr, g_din, g_we);
         ref_mem[g_addr[9:2]] = merge(ref_mem[g_addr[9:2]], g_din, g_we);
      end
      // Every transaction with graphics ends with a graphics grant.
      if (g_en) tb_starve = 0;
      exp_stalls = 2 + d + (c_store ? 0 : lat);

      rdy_delay = d;
      rd_lat    = lat;
      cpu_re    = c_en && c_re;
      cpu_we    = c_en ? c_we : 4'h0;
      cpu_addr  = c_addr;
      cpu_din   = c_din;
      gfx_valid = g_en;
      gfx_addr  = g_en ? g_addr : '0;
      gfx_din   = g_en ? g_din : '0;
      gfx_we    = g_en ? g_we : 4'h0;
      #1;
      stalls = 0;
      c_pend = c_req;
      g_pend = g_en;
      g_drop = 1'b0;
      for (int cyc = 0; cyc < 100 && (c_pend || g_pend); cyc++) begin
         if (g_drop) begin
            gfx_valid = 1'b0;
            g_pend    = 1'b0;
            g_drop    = 1'b0;
         end
         if (c_pend) begin
            if (cpu_stall) stalls++;
            else begin
               check({tag, "_cpu_dout"}, cpu_dout, dout_model);
               if (!gfx_first) check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
               cpu_re = 1'b0;
               cpu_we = 4'h0;
               c_pend = 1'b0;
            end
         end
         if (g_pend && gfx_ready) g_drop = 1'b1;
         if (c_pend || g_pend) step();
      end
      if (c_pend || g_pend) begin
         n_cmp++;
         n_bad++;
         $error("FAIL %s_timeout: observed pending=%0d expected pending=0", tag, 32'(c_pend || g_pend));
         cpu_re = 1'b0; cpu_we = 4'h0; gfx_valid = 1'b0;
      end
      step();
      compare_reqs(tag);
   endtask

   initial begin
      int          c_acc, g_acc;
      logic        g_drop;
      logic [31:0] a, ga;
      rst = 1'b0; cpu_re = 1'b0; cpu_we = 4'h0; cpu_addr = '0; cpu_din = '0;
      gfx_valid = 1'b0; gfx_addr = '0; gfx_din = '0; gfx_we = 4'h0;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i]  = (i * 32'h0100_0193) ^ 32'hA5A5_0000;
         resp_mem[i] = (i * 32'h0100_0193) ^ 32'hA5A5_0000;
      end
      ref_mem[65]  = 32'h1234_5678;
      resp_mem[65] = 32'h1234_5678;
      dout_model = '0;
      tb_starve  = 0;

      // Reset state
      repeat (3) step();
      rst = 1'b1;
      check("rst_mem_req_valid", 32'(mem_req_valid), 0);
      check("rst_cpu_stall", 32'(cpu_stall), 0);
      check("rst_cpu_dout", cpu_dout, 0);
      check("rst_gfx_ready", 32'(gfx_ready), 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_we", 32'(mem_we), 0);

      // Directed store and load
      do_txn("store100", 1'b1, 1'b0, 4'hF, 32'h100, 32'hDEAD_BEEF, 1'b0, '0, '0, 4'h0, 0, 1);
      do_txn("load104", 1'b1, 1'b1, 4'h0, 32'h104, 32'h0, 1'b0, '0, '0, 4'h0, 0, 3);
      check("load104_value", cpu_dout, 32'h1234_5678);

      // Starvation: CPU loads back to back while graphics waits
      a  = 32'h040;
      ga = 32'h080;
      for (int i = 0; i < 11; i++) begin
         if (i == 4 || i == 9) begin
            expect_req(1'b1, ga, 32'hCAFE_0001, 4'hF);
            ref_mem[ga[9:2]] = merge(ref_mem[ga[9:2]], 32'hCAFE_0001, 4'hF);
         end else expect_req(1'b0, a, 32'h5555_AAAA, 4'h0);
      end
      dout_model = ref_mem[a[9:2]];
      rdy_delay = 0; rd_lat = 1;
      cpu_re = 1'b1; cpu_we = 4'h0; cpu_addr = a; cpu_din = 32'h5555_AAAA;
      gfx_valid = 1'b1; gfx_addr = ga; gfx_din = 32'hCAFE_0001; gfx_we = 4'hF;
      #1;
      c_acc = 0; g_acc = 0; g_drop = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (g_drop) begin gfx_valid = 1'b0; g_drop = 1'b0; end
         if (gfx_valid && gfx_ready) begin
            g_acc++;
            if (g_acc == 2) g_drop = 1'b1;
         end
         if (cpu_re && !cpu_stall) begin
            c_acc++;
            check("starve_cpu_dout", cpu_dout, dout_model);
            if (c_acc == 9) cpu_re = 1'b0;
         end
         if (c_acc == 9 && g_acc == 2) break;
         step();
      end
      check("starve_cpu_grants", 32'(c_acc), 9);
      check("starve_gfx_grants", 32'(g_acc), 2);
      gfx_valid = 1'b0;
      step();
      step();
      compare_reqs("starve");
      tb_starve = 0;

      // Graphics held off by memory; a CPU load arrives meanwhile
      rdy_delay = 5; rd_lat = 2;
      ga = 32'h0C0;
      expect_req(1'b1, ga, 32'h0BAD_F00D, 4'h3);
      ref_mem[ga[9:2]] = merge(ref_mem[ga[9:2]], 32'h0BAD_F00D, 4'h3);
      expect_req(1'b0, ga, 32'h0, 4'h0);
      dout_model = ref_mem[ga[9:2]];
      gfx_valid = 1'b1; gfx_addr = ga; gfx_din = 32'h0BAD_F00D; gfx_we = 4'h3;
      step();
      cpu_re = 1'b1; cpu_addr = ga; cpu_din = '0; cpu_we = 4'h0;
      #1;
      for (int k = 0; k < 5; k++) begin
         check("gfxhold_valid", 32'(mem_req_valid), 1);
         check("gfxhold_addr", mem_addr, ga);
         check("gfxhold_din", mem_din, 32'h0BAD_F00D);
         check("gfxhold_we", 32'(mem_we), 32'h3);
         check("gfxhold_ready", 32'(gfx_ready), 0);
         check("gfxhold_cpu_stall", 32'(cpu_stall), 1);
         step();
      end
      check("gfxhold_accept", 32'(gfx_ready), 1);
      rdy_delay = 0;
      step();
      gfx_valid = 1'b0;
      #1;
      begin
         int cyc;
         for (cyc = 0; cyc < 30 && cpu_stall; cyc++) step();
         check("gfxhold_cpu_served", 32'(cpu_stall), 0);
      end
      check("gfxhold_cpu_dout", cpu_dout, dout_model);
      cpu_re = 1'b0;
      step();
      compare_reqs("gfxhold");
      tb_starve = 0;

      // Randomized transactions
      for (int t = 0; t < 40; t++) begin
         int          kind;
         logic [31:0] ca, cg, cd, gd;
         logic [3:0]  cw, gw;
         logic        cr;
         kind = $urandom_range(0, 3);
         ca = 32'($urandom_range(0, 255)) << 2;
         cg = 32'($urandom_range(0, 255)) << 2;
         cd = $urandom;
         gd = $urandom;
         gw = 4'($urandom_range(1, 15));
         cr = 1'($urandom_range(0, 1));
         cw = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         case (kind)
            0: do_txn("rnd_store", 1'b1, cr, 4'($urandom_range(1, 15)), ca, cd, 1'b0, '0, '0, 4'h0,
                      $urandom_range(0, 3), $urandom_range(1, 4));
            1: do_txn("rnd_load", 1'b1, 1'b1, 4'h0, ca, cd, 1'b0, '0, '0, 4'h0,
                      $urandom_range(0, 3), $urandom_range(1, 4));
            2: do_txn("rnd_gfx", 1'b0, 1'b0, 4'h0, '0, '0, 1'b1, cg, gd, gw,
                      $urandom_range(0, 3), 1);
            default: do_txn("rnd_both", 1'b1, 1'b1, cw, ca, cd, 1'b1, cg, gd, gw,
                            $urandom_range(0, 3), $urandom_range(1, 4));
         endcase
      end

      // Reset while waiting for read data, then a stray read return
      rdy_delay = 0; rd_lat = 6;
      expect_req(1'b0, 32'h010, 32'h0, 4'h0);
      cpu_re = 1'b1; cpu_we = 4'h0; cpu_addr = 32'h010; cpu_din = '0;
      step();
      step();
      check("rstmid_stalled", 32'(cpu_stall), 1);
      rst = 1'b0; cpu_re = 1'b0;
      step();
      rst = 1'b1;
      dout_model = '0;
      tb_starve  = 0;
      check("rstmid_mem_req_valid", 32'(mem_req_valid), 0);
      check("rstmid_gfx_ready", 32'(gfx_ready), 0);
      check("rstmid_cpu_stall", 32'(cpu_stall), 0);
      check("rstmid_cpu_dout", cpu_dout, 0);
      check("rstmid_mem_addr", mem_addr, 0);
      repeat (7) step();
      check("stray_cpu_dout", cpu_dout, 0);
      check("stray_mem_req_valid", 32'(mem_req_valid), 0);
      check("stray_cpu_stall", 32'(cpu_stall), 0);
      compare_reqs("rstmid");
      do_txn("post_rst_store", 1'b1, 1'b0, 4'h5, 32'h200, 32'h0102_0304, 1'b0, '0, '0, 4'h0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
